// File: rtl/move_request_fsm.sv
// Turn controller for the 2048 movement engine: issue a move, await the result, spawn a tile, commit.
// Optional MOVE_TIMEOUT_EN aborts a turn whose engine never reports ready within TIMEOUT cycles.
`timescale 1ns/1ps
module move_request_fsm #(
    parameter logic [11:0] WIN_VALUE = 12'd2048,
    parameter logic [15:0] LFSR_SEED = 16'hACE1,
    parameter int          TIMEOUT   = 64
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [3:0]             btn,
    input  logic [3:0][3:0][11:0]  board_in,
    output logic                   mv_enable,
    output logic [3:0]             mv_direction,
    input  logic [3:0][3:0][11:0]  mv_matrix,
    input  logic                   mv_ready,
    output logic [3:0][3:0][11:0]  board_out,
    output logic                   board_we,
    output logic                   busy,
    output logic                   no_move,
    output logic                   won,
    output logic                   lost,
    output logic [15:0]            move_count
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_ISSUE  = 3'd1;
    localparam logic [2:0] S_WAIT   = 3'd2;
    localparam logic [2:0] S_CMP    = 3'd3;
    localparam logic [2:0] S_SPAWN  = 3'd4;
    localparam logic [2:0] S_COMMIT = 3'd5;

    logic [2:0]        r_state;
    logic [15:0]       r_lfsr;
    logic [3:0]        r_dir;
    logic [15:0][11:0] r_snap;
    logic [15:0][11:0] r_res;
    logic [15:0][11:0] r_board;
    logic [3:0]        r_idx;
    logic [4:0]        r_scan;
    logic              r_no_move;
    logic              r_won;
    logic              r_lost;
    logic [15:0]       r_count;

    logic              w_fb;
    logic              w_onehot;
    logic              w_same;
    logic              w_empty;
    logic [11:0]       w_spawn_val;
    logic [15:0][11:0] w_res_spawn;
    logic              w_win;
    logic              w_has_zero;
    logic              w_pair;
    logic              w_lose;
    logic              w_timeout;

    assign w_fb        = r_lfsr[0] ^ r_lfsr[2] ^ r_lfsr[3] ^ r_lfsr[5];
    assign w_onehot    = (btn != 4'b0) && ((btn & (btn - 4'd1)) == 4'b0);
    assign w_same      = (r_res == r_snap);
    assign w_empty     = (r_res[r_idx] == 12'd0);
    assign w_spawn_val = (r_lfsr[7:5] != 3'b0) ? 12'd2 : 12'd4;

    always_comb begin
        w_res_spawn = r_res;
        if (w_empty) w_res_spawn[r_idx] = w_spawn_val;
    end

    // Cell i is row*4+col; horizontal pairs stay inside a row.
    always_comb begin
        w_win      = 1'b0;
        w_has_zero = 1'b0;
        w_pair     = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (r_res[i] >= WIN_VALUE) w_win = 1'b1;
            if (r_res[i] == 12'd0) w_has_zero = 1'b1;
        end
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 3; c++) begin
                if (r_res[r*4+c] == r_res[r*4+c+1]) w_pair = 1'b1;
            end
        end
        for (int i = 0; i < 12; i++) begin
            if (r_res[i] == r_res[i+4]) w_pair = 1'b1;
        end
    end

    assign w_lose = !w_has_zero && !w_pair;

`ifdef MOVE_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] r_wcnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wcnt <= '0;
        end else if (r_state == S_WAIT) begin
            r_wcnt <= r_wcnt + 1'b1;
        end else begin
            r_wcnt <= '0;
        end
    end

    assign w_timeout = (r_wcnt == TW'(TIMEOUT - 1));
`else
    assign w_timeout = (TIMEOUT < 0);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_lfsr    <= LFSR_SEED;
            r_dir     <= 4'b0;
            r_snap    <= '0;
            r_res     <= '0;
            r_board   <= '0;
            r_idx     <= 4'd0;
            r_scan    <= 5'd0;
            r_no_move <= 1'b0;
            r_won     <= 1'b0;
            r_lost    <= 1'b0;
            r_count   <= 16'd0;
        end else begin
            r_lfsr    <= {w_fb, r_lfsr[15:1]};
            r_no_move <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_onehot && !r_won && !r_lost) begin
                        r_dir   <= btn;
                        r_snap  <= board_in;
                        r_state <= S_ISSUE;
                    end
                end
                S_ISSUE: r_state <= S_WAIT;
                S_WAIT: begin
                    if (mv_ready) begin
                        r_res   <= mv_matrix;
                        r_state <= S_CMP;
                    end else if (w_timeout) begin
                        r_no_move <= 1'b1;
                        r_state   <= S_IDLE;
                    end
                end
                S_CMP: begin
                    if (w_same) begin
                        r_no_move <= 1'b1;
                        r_state   <= S_IDLE;
                    end else begin
                        r_idx   <= r_lfsr[3:0];
                        r_scan  <= 5'd0;
                        r_state <= S_SPAWN;
                    end
                end
                S_SPAWN: begin
                    r_res <= w_res_spawn;
                    // A full scan with no empty cell commits unchanged.
                    if (w_empty || r_scan == 5'd15) begin
                        r_board <= w_res_spawn;
                        r_state <= S_COMMIT;
                    end else begin
                        r_idx  <= r_idx + 4'd1;
                        r_scan <= r_scan + 5'd1;
                    end
                end
                S_COMMIT: begin
                    r_count <= r_count + 16'd1;
                    r_won   <= r_won | w_win;
                    r_lost  <= r_lost | w_lose;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy         = (r_state != S_IDLE);
    assign mv_enable    = (r_state == S_ISSUE) || (r_state == S_WAIT);
    assign mv_direction = mv_enable ? r_dir : 4'b0;
    assign board_we     = (r_state == S_COMMIT);
    assign board_out    = r_board;
    assign no_move      = r_no_move;
    assign won          = r_won;
    assign lost         = r_lost;
    assign move_count   = r_count;

endmodule

// File: tb/tb_move_request_fsm.sv
// Bench for move_request_fsm: per-turn reference model plus directed moves.
// Timeout scenario runs only when MOVE_TIMEOUT_EN is defined.
`timescale 1ns/1ps
module tb_move_request_fsm;

    localparam int TMO = 8;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [3:0]            btn;
    logic [3:0][3:0][11:0] board_in;
    logic                  mv_enable;
    logic [3:0]            mv_direction;
    logic [3:0][3:0][11:0] mv_matrix;
    logic                  mv_ready;
    logic [3:0][3:0][11:0] board_out;
    logic                  board_we;
    logic                  busy;
    logic                  no_move;
    logic                  won;
    logic                  lost;
    logic [15:0]           move_count;

    always #5 clk = ~clk;

    move_request_fsm #(
        .WIN_VALUE(12'd2048),
        .LFSR_SEED(16'hACE1),
        .TIMEOUT(TMO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .btn(btn),
        .board_in(board_in),
        .mv_enable(mv_enable),
        .mv_direction(mv_direction),
        .mv_matrix(mv_matrix),
        .mv_ready(mv_ready),
        .board_out(board_out),
        .board_we(board_we),
        .busy(busy),
        .no_move(no_move),
        .won(won),
        .lost(lost),
        .move_count(move_count)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [191:0] act,
                       input logic [191:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %0h want %0h", nm, $time, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [15:0]       lfsr_m;
    logic              e_busy, e_en, e_we, e_nm;
    logic [3:0]        e_dir;
    logic              won_m, lost_m;
    logic [15:0]       cnt_m;
    logic [15:0][11:0] brd_m;
    logic              s_rst, s_rdy;
    logic [3:0]        s_btn;
    logic [15:0][11:0] s_mat, s_bin;

    function automatic logic [15:0] lfsr_nx(input logic [15:0] v);
        return {v[0] ^ v[2] ^ v[3] ^ v[5], v[15:1]};
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) lfsr_m <= 16'hACE1;
        else     lfsr_m <= lfsr_nx(lfsr_m);
    end

    function automatic logic any_win(input logic [15:0][11:0] b);
        for (int i = 0; i < 16; i++) if (b[i] >= 12'd2048) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic stuck(input logic [15:0][11:0] b);
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (b[r*4+c] == 0) return 1'b0;
                if (c < 3 && b[r*4+c] == b[r*4+c+1]) return 1'b0;
                if (r < 3 && b[r*4+c] == b[(r+1)*4+c]) return 1'b0;
            end
        end
        return 1'b1;
    endfunction

    task automatic set_idle(input logic nm);
        e_busy = 1'b0; e_en = 1'b0; e_dir = 4'b0; e_we = 1'b0; e_nm = nm;
    endtask

    task automatic reset_m();
        won_m = 1'b0; lost_m = 1'b0; cnt_m = 16'd0; brd_m = '0;
        set_idle(1'b0);
    endtask

    task automatic step();
        @(posedge clk);
        s_rst = rst; s_btn = btn; s_rdy = mv_ready;
        s_mat = mv_matrix; s_bin = board_in;
        #1;
    endtask

    task automatic turn();
        logic [3:0]        dir, idx;
        logic [15:0][11:0] snap, res;
        logic [15:0]       lfc;
        int                w, k;
        bit                got, done;
        dir = s_btn; snap = s_bin;
        e_busy = 1'b1; e_en = 1'b1; e_dir = dir; e_we = 1'b0; e_nm = 1'b0;
        step(); if (s_rst) return;
        w = 0; got = 0;
        while (!got) begin
            step(); if (s_rst) return;
            w++;
            if (s_rdy) got = 1;
`ifdef MOVE_TIMEOUT_EN
            else if (w == TMO) begin set_idle(1'b1); return; end
`endif
        end
        res = s_mat; e_en = 1'b0; e_dir = 4'b0; lfc = lfsr_m;
        step(); if (s_rst) return;
        if (res == snap) begin set_idle(1'b1); return; end
        idx = lfc[3:0]; k = 0; done = 0;
        while (!done) begin
            if (res[idx] == 12'd0) begin
                res[idx] = (lfsr_m[7:5] != 3'b0) ? 12'd2 : 12'd4;
                done = 1;
            end else begin
                idx = idx + 4'd1; k++;
                if (k == 16) done = 1;
            end
            step(); if (s_rst) return;
        end
        e_we = 1'b1; brd_m = res;
        step(); if (s_rst) return;
        cnt_m = cnt_m + 16'd1;
        won_m = won_m | any_win(res);
        lost_m = lost_m | stuck(res);
        set_idle(1'b0);
    endtask

    initial begin
        reset_m();
        forever begin
            step();
            if (s_rst) reset_m();
            else if ($onehot(s_btn) && !won_m && !lost_m) begin
                turn();
                if (s_rst) reset_m();
            end else set_idle(1'b0);
        end
    end

    // ---------------- per-cycle compare ----------------
    initial forever begin
        @(negedge clk);
        if (rst) begin
            chk("reset_status", {busy, mv_enable, mv_direction, board_we, no_move,
                                 won, lost, move_count}, '0);
            chk("reset_board", board_out, '0);
        end else begin
            chk("status", {busy, mv_enable, mv_direction, board_we, no_move,
                           won, lost, move_count},
                {e_busy, e_en, e_dir, e_we, e_nm, won_m, lost_m, cnt_m});
            chk("board", board_out, brd_m);
        end
    end

    int n_we = 0, n_nm = 0, n_busy = 0;
    initial forever begin
        @(negedge clk);
        if (!rst) begin
            if (board_we) n_we++;
            if (no_move)  n_nm++;
            if (busy)     n_busy++;
        end
    end

    // ---------------- stimulus ----------------
    task automatic wait_idle(input string nm);
        int c;
        c = 0;
        @(negedge clk);
        while (busy && c < 100) begin @(negedge clk); c++; end
        n_vec++;
        if (busy) begin
            n_err++;
            $display("FAIL %s: busy stuck got %0b want 0", nm, busy);
        end
    endtask

    task automatic move(input logic [3:0] b, input logic [191:0] m,
                        input int d, input logic [3:0] hold);
        @(posedge clk); #1 btn = b;
        @(posedge clk); #1 btn = hold;
        if (d > 0) begin
            repeat (d) @(posedge clk);
            #1 mv_ready = 1'b1; mv_matrix = m; btn = 4'b0;
            @(posedge clk); #1 mv_ready = 1'b0;
        end
        wait_idle("turn_end");
    endtask

    function automatic int nz(input logic [3:0][3:0][11:0] b);
        int n;
        n = 0;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) if (b[r][c] != 0) n++;
        return n;
    endfunction

    function automatic int sum(input logic [3:0][3:0][11:0] b);
        int s;
        s = 0;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) s += int'(b[r][c]);
        return s;
    endfunction

    logic [3:0][3:0][11:0] b0, m;
    int nm0, nb0;

    initial begin
        rst = 1'b1; btn = 4'b0; board_in = '0; mv_matrix = '0; mv_ready = 1'b0;
        repeat (2) @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("init_busy", busy, 0);
        chk("init_count", move_count, 0);

        @(posedge clk); #1 btn = 4'b0011;
        repeat (3) @(posedge clk); #1 btn = 4'b0;
        @(negedge clk);
        chk("multi_bit_ignored", busy, 0);

        b0 = '0; b0[0][0] = 12'd2; b0[0][1] = 12'd2; board_in = b0;
        m = '0; m[0][0] = 12'd4;
        move(4'b0100, m, 3, 4'b0000);
        chk("basic_cell00", board_out[0][0], 12'd4);
        chk("basic_count", move_count, 1);
        chk("basic_we_once", n_we, 1);
        chk("basic_two_tiles", nz(board_out), 2);
        chk("basic_new_2or4", (sum(board_out) == 6) || (sum(board_out) == 8), 1);

        board_in = board_out;
        m = board_out; m[0][0] = 12'd0; m[0][3] = 12'd4;
        move(4'b0001, m, 2, 4'b1000);
        chk("busy_btn_ignored_count", move_count, 2);

        board_in = board_out; nm0 = n_nm;
        move(4'b0010, board_out, 2, 4'b0000);
        chk("nochange_pulse", n_nm - nm0, 1);
        chk("nochange_no_we", n_we, 2);
        chk("nochange_count", move_count, 2);

`ifdef MOVE_TIMEOUT_EN
        nm0 = n_nm;
        move(4'b0001, '0, 0, 4'b0000);
        chk("timeout_pulse", n_nm - nm0, 1);
        chk("timeout_no_we", n_we, 2);
`endif

        board_in = board_out;
        m = board_out; m[1][1] = 12'd2048;
        move(4'b1000, m, 1, 4'b0000);
        chk("win_set", won, 1);
        chk("win_count", move_count, 3);
        @(posedge clk); #1 btn = 4'b0100;
        repeat (3) @(posedge clk); #1 btn = 4'b0;
        @(negedge clk);
        chk("win_blocks_btn", busy, 0);

        @(posedge clk); #1 rst = 1'b1;
        @(negedge clk);
        chk("rst_clears_won", won, 0);
        @(posedge clk); #1 rst = 1'b0;

        board_in = b0;
        @(posedge clk); #1 btn = 4'b0100;
        @(posedge clk); #1 btn = 4'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("midwait_enable", mv_enable, 1);
        @(posedge clk); #1 rst = 1'b1;
        @(negedge clk);
        chk("midrst_busy", busy, 0);
        chk("midrst_dir", mv_direction, 0);
        @(posedge clk); #1 rst = 1'b0;

        m = '0; m[0][0] = 12'd4;
        move(4'b0100, m, 1, 4'b0000);
        chk("fresh_count", move_count, 1);
        chk("fresh_cell00", board_out[0][0], 12'd4);

        board_in = '0;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                m[r][c] = ((r + c) % 2 == 1) ? 12'd4 : 12'd2;
        nb0 = n_busy;
        move(4'b0001, m, 1, 4'b0000);
        chk("lose_set", lost, 1);
        chk("lose_busy_cycles", n_busy - nb0, 20);
        chk("lose_no_spawn", board_out, m);
        chk("lose_count", move_count, 2);
        @(posedge clk); #1 btn = 4'b0010;
        repeat (2) @(posedge clk); #1 btn = 4'b0;
        @(negedge clk);
        chk("lose_blocks_btn", busy, 0);

        repeat (2) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/move_request_fsm.md
Name: move_request_fsm

Overview:
Turn controller and initiator for the 2048 movement engine. It accepts one-hot direction requests and drives the engine's enable and direction, then waits for the engine's ready. It compares the moved board with the pre-move snapshot, spawns a new tile into a pseudo-random empty cell, and commits the board. It sits between the input/debounce logic and the board register, and is the requesting side of the enable/direction/ready interface.

Parameters:
WIN_VALUE, 12'd2048, tile value that sets won.
LFSR_SEED, 16'hACE1, LFSR reset value; must be nonzero.
TIMEOUT, 64, WAIT-state cycle limit; used only with MOVE_TIMEOUT_EN.

Ports:
clk  in  1  system clock, all state on rising edge.
rst  in  1  asynchronous, active-high reset.
btn  in  4  one-hot move request: bit0 up, bit1 down, bit2 left, bit3 right.
board_in  in  12x4x4  current committed board, indexed [row][col].
mv_enable  out  1  enable to the movement engine.
mv_direction  out  4  one-hot direction to the engine.
mv_matrix  in  12x4x4  moved board from the engine.
mv_ready  in  1  engine done/ready.
board_out  out  12x4x4  board to commit.
board_we  out  1  one-cycle commit strobe.
busy  out  1  high in every state except IDLE.
no_move  out  1  one-cycle pulse when a move leaves the board unchanged.
won  out  1  sticky; cleared only by reset.
lost  out  1  sticky; cleared only by reset.
move_count  out  16  committed-move counter; wraps 16'hFFFF to 0.

Behaviour:
- Reset: all outputs and state go to 0 (board_out all-zero cells, mv_direction 4'b0000), state goes to IDLE, and the LFSR loads LFSR_SEED. Assertion mid-operation aborts the turn and discards any captured data.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11. Advances every cycle in every state.
- IDLE:
  - If btn has exactly one bit set and won=lost=0: latch dir_q=btn and snap_q=board_in, then go to ISSUE.
  - Zero bits, multiple bits, or won/lost set: stay in IDLE.
  - btn is ignored in all other states.
- ISSUE (1 cycle): mv_enable=1, mv_direction=dir_q. mv_ready is ignored this cycle. Go to WAIT.
- WAIT: mv_enable=1 and mv_direction=dir_q held stable. On the first cycle with mv_ready=1, capture res_q=mv_matrix and go to COMPARE.
- mv_direction is 0 outside ISSUE/WAIT. mv_ready outside WAIT is ignored.
- COMPARE (1 cycle):
  - res_q equals snap_q: pulse no_move, go to IDLE, no commit.
  - Otherwise: load scan index idx=lfsr[3:0] and a 5-bit scan counter of 0, then go to SPAWN.
- SPAWN: one cell per cycle. Cell index = row*4+col.
  - If res_q[idx]==0: write 12'd2 if lfsr[7:5]!=0, else 12'd4, then go to COMMIT.
  - Otherwise: idx=idx+1 mod 16 and count+1.
  - After 16 non-empty cells: go to COMMIT with no spawn.
  - Maximum latency is 16 cycles.
- COMMIT (1 cycle):
  - board_out=res_q and board_we=1; board_out holds its value until the next commit.
  - move_count increments.
  - won sets if any cell of res_q >= WIN_VALUE.
  - lost sets if res_q has no zero cell and no horizontally or vertically adjacent equal pair.
  - Go to IDLE.
- Minimum request-to-commit latency (engine ready on first WAIT cycle, empty cell at first scan): ISSUE, WAIT, COMPARE, SPAWN, COMMIT = 5 cycles after acceptance.

Optional Feature:
MOVE_TIMEOUT_EN
- Defined: a cycle counter runs in WAIT. If mv_ready has not been seen after TIMEOUT cycles in WAIT, pulse no_move, drop mv_enable, and go to IDLE with no commit. A mv_ready that arrives later is ignored.
- Undefined: WAIT lasts indefinitely; no counter logic is synthesised.

Test Plan:
- Reset check: assert rst mid-WAIT -> next cycle all outputs 0, busy=0, LFSR=16'hACE1, and a fresh btn=4'b0100 is accepted normally.
- Basic move: board_in row0 = {2,2,0,0}, rest 0; btn=4'b0100; engine model returns row0 {4,0,0,0} with ready 3 cycles after enable -> mv_direction=4'b0100 throughout ISSUE/WAIT, exactly one board_we, board_out[0][0]=4, exactly one new 2 or 4 in an empty cell, move_count=1.
- No-change move: engine returns a matrix equal to board_in -> no_move pulses one cycle, board_we never asserts, move_count unchanged.
- Request filtering: btn=4'b0011 in IDLE -> ignored. btn=4'b1000 while busy -> ignored; only the first direction is issued.
- Win: engine returns a board with a 2048 cell -> won=1 after COMMIT; further btn are ignored until rst.
- Lose: engine returns a full board with no equal neighbours -> SPAWN runs 16 cycles, commits with no spawn, lost=1.
- With MOVE_TIMEOUT_EN and TIMEOUT=8: engine never asserts ready -> no_move pulses after 8 WAIT cycles, state returns to IDLE, no commit.
